// File: rtl/tempsense_scheduler.sv
// tempsense_scheduler: periodic sequencer for the temperature sensor conversion path.
// Raises temp_en once per programmed period, waits for a fresh ADC DONE edge,
// publishes the conversion word with high/low threshold alarms and flags timeouts.
// Optional sample averaging is compiled in with `define TSCHED_AVG_EN, which also
// adds the AVG_LOG2 parameter (log2 of samples averaged per published result).
module tempsense_scheduler #(
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned PERIOD_W    = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
`ifdef TSCHED_AVG_EN
    ,
    parameter int unsigned AVG_LOG2    = 2
`endif
) (
    input  logic                HF_CLK,
    input  logic                RST_sync,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                adc_done,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic [DATA_W-1:0]   thr_hi,
    input  logic [DATA_W-1:0]   thr_lo,
    input  logic                err_clr,
    output logic                temp_en,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    output logic                alarm_hi,
    output logic                alarm_lo,
    output logic                timeout_err,
    output logic                busy
);

    localparam int unsigned TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned CNT_W = (PERIOD_W > TO_W) ? PERIOD_W : TO_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gap_q, gap_d;
    logic               abort_q, abort_d;
    logic               done_q;
    logic               terr_d;
    logic               done_edge_c;
    logic               sample_ok_c;
    logic               pub_c;
    logic [DATA_W-1:0]  pub_val_c;
    logic [DATA_W-1:0]  result_d;
    logic               rv_d, ahi_d, alo_d;

`ifdef TSCHED_AVG_EN
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]   acc_q, acc_d, sum_c;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic               clr_avg_c;
`endif

    // Rising edge of DONE; a level already high on REQ entry is not an edge.
    assign done_edge_c = adc_done & ~done_q;

    // Next-state logic: conversion request, 2-cycle re-arm gap, period wait.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        abort_d     = abort_q;
        terr_d      = err_clr ? 1'b0 : timeout_err;
        sample_ok_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end
            end
            ST_REQ: begin
                // A conversion in flight is never truncated; a disable only discards it.
                abort_d = abort_q | ~enable;
                if (done_edge_c) begin
                    state_d     = ST_GAP;
                    gap_d       = 1'b0;
                    sample_ok_c = ~(abort_q | ~enable);
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_GAP;
                    gap_d   = 1'b0;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (period == '0) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(period);
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_REQ;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result datapath: optional averaging, publication and alarm compare.
    always_comb begin
        pub_c     = 1'b0;
        pub_val_c = adc_data;
`ifdef TSCHED_AVG_EN
        acc_d     = acc_q;
        smp_d     = smp_q;
        sum_c     = acc_q + ACC_W'(adc_data);
        clr_avg_c = (state_q == ST_REQ) && (state_d == ST_GAP) && !sample_ok_c;
        if (clr_avg_c) begin
            acc_d = '0;
            smp_d = '0;
        end else if (sample_ok_c) begin
            if (smp_q == SMP_LAST) begin
                pub_c     = 1'b1;
                pub_val_c = DATA_W'(sum_c >> AVG_LOG2);
                acc_d     = '0;
                smp_d     = '0;
            end else begin
                acc_d = sum_c;
                smp_d = smp_q + SMP_W'(1);
            end
        end
`else
        pub_c     = sample_ok_c;
`endif
        result_d = result;
        rv_d     = 1'b0;
        ahi_d    = alarm_hi;
        alo_d    = alarm_lo;
        if (pub_c) begin
            result_d = pub_val_c;
            rv_d     = 1'b1;
            ahi_d    = (pub_val_c > thr_hi);
            alo_d    = (pub_val_c < thr_lo);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge HF_CLK) begin
        if (RST_sync) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gap_q        <= 1'b0;
            abort_q      <= 1'b0;
            done_q       <= 1'b0;
            temp_en      <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            alarm_hi     <= 1'b0;
            alarm_lo     <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef TSCHED_AVG_EN
            acc_q        <= '0;
            smp_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            abort_q      <= abort_d;
            done_q       <= adc_done;
            temp_en      <= (state_d == ST_REQ);
            busy         <= (state_d != ST_IDLE);
            result       <= result_d;
            result_valid <= rv_d;
            alarm_hi     <= ahi_d;
            alarm_lo     <= alo_d;
            timeout_err  <= terr_d;
`ifdef TSCHED_AVG_EN
            acc_q        <= acc_d;
            smp_q        <= smp_d;
`endif
        end
    end

endmodule

// File: tb/tb_tempsense_scheduler.sv
// Self-checking bench for tempsense_scheduler: a behavioural timeline model
// checked every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_tempsense_scheduler;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned TO_CYC   = 16;
`ifdef TSCHED_AVG_EN
    localparam int unsigned AVG_LOG2 = 2;
`endif

    logic                HF_CLK = 1'b0;
    logic                RST_sync = 1'b1;
    logic                enable = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic                adc_done = 1'b0;
    logic [DATA_W-1:0]   adc_data = '0;
    logic [DATA_W-1:0]   thr_hi = '1;
    logic [DATA_W-1:0]   thr_lo = '0;
    logic                err_clr = 1'b0;
    logic                temp_en;
    logic [DATA_W-1:0]   result;
    logic                result_valid;
    logic                alarm_hi;
    logic                alarm_lo;
    logic                timeout_err;
    logic                busy;

    int n_chk  = 0;
    int n_fail = 0;

    tempsense_scheduler #(
        .DATA_W      (DATA_W),
        .PERIOD_W    (PERIOD_W),
        .TIMEOUT_CYC (TO_CYC)
`ifdef TSCHED_AVG_EN
        ,
        .AVG_LOG2    (AVG_LOG2)
`endif
    ) dut (
        .HF_CLK       (HF_CLK),
        .RST_sync     (RST_sync),
        .enable       (enable),
        .period       (period),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .err_clr      (err_clr),
        .temp_en      (temp_en),
        .result       (result),
        .result_valid (result_valid),
        .alarm_hi     (alarm_hi),
        .alarm_lo     (alarm_lo),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 HF_CLK = ~HF_CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 converting (temp_en high), 2 low phase after a conversion.
    // In the low phase, pos 0/1 are the two re-arm cycles, then plen wait cycles.
    int                m_mode = 0;
    int                m_age = 0;
    int                m_pos = 0;
    int                m_plen = 0;
    int                m_sum = 0;
    int                m_nacc = 0;
    bit                m_abort = 0;
    bit                m_prev_done = 0;
    bit                m_live = 0;
    bit                m_dedge;
    bit                m_to;
    logic [DATA_W-1:0] m_result = '0;
    bit                m_rv = 0;
    bit                m_ahi = 0;
    bit                m_alo = 0;
    bit                m_terr = 0;

    task automatic emit(input int v);
        m_result = DATA_W'(v);
        m_rv     = 1;
        m_ahi    = (v > int'(thr_hi));
        m_alo    = (v < int'(thr_lo));
    endtask

    task automatic take(input int d);
`ifdef TSCHED_AVG_EN
        m_sum  = m_sum + d;
        m_nacc = m_nacc + 1;
        if (m_nacc == (1 << AVG_LOG2)) begin
            emit(m_sum / (1 << AVG_LOG2));
            m_sum  = 0;
            m_nacc = 0;
        end
`else
        emit(d);
`endif
    endtask

    always @(posedge HF_CLK) begin
        if (RST_sync) begin
            m_live = 1; m_mode = 0; m_age = 0; m_pos = 0; m_plen = 0;
            m_abort = 0; m_prev_done = 0; m_sum = 0; m_nacc = 0;
            m_result = '0; m_rv = 0; m_ahi = 0; m_alo = 0; m_terr = 0;
        end else begin
            m_dedge = adc_done && !m_prev_done;
            m_to    = 0;
            m_rv    = 0;
            case (m_mode)
                0: if (enable) begin m_mode = 1; m_age = 0; m_abort = 0; end
                1: begin
                    m_abort = m_abort || !enable;
                    if (m_dedge) begin
                        if (m_abort) begin m_sum = 0; m_nacc = 0; end
                        else take(int'(adc_data));
                        m_mode = 2; m_pos = 0;
                    end else if (m_age == TO_CYC - 1) begin
                        m_to = 1; m_sum = 0; m_nacc = 0; m_mode = 2; m_pos = 0;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    if (m_pos == 0) m_pos = 1;
                    else if (!enable) m_mode = 0;
                    else begin
                        if (m_pos == 1) m_plen = int'(period);
                        if (m_pos == m_plen + 1) begin m_mode = 1; m_age = 0; m_abort = 0; end
                        else m_pos++;
                    end
                end
            endcase
            m_terr = m_to ? 1'b1 : (err_clr ? 1'b0 : m_terr);
            m_prev_done = adc_done;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge HF_CLK) begin
        if (m_live) begin
            chk("m_temp_en", int'(temp_en), int'(m_mode == 1));
            chk("m_busy", int'(busy), int'(m_mode != 0));
            chk("m_result", int'(result), int'(m_result));
            chk("m_result_valid", int'(result_valid), int'(m_rv));
            chk("m_alarm_hi", int'(alarm_hi), int'(m_ahi));
            chk("m_alarm_lo", int'(alarm_lo), int'(m_alo));
            chk("m_timeout_err", int'(timeout_err), int'(m_terr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge HF_CLK);
        #1;
    endtask

    task automatic wait_te(input logic val, input int lim);
        int n = 0;
        while (temp_en !== val && n < lim) begin
            tick();
            n++;
        end
        chk("wait_temp_en", int'(temp_en), int'(val));
    endtask

    // Done edge dly cycles after temp_en is first seen high; returns in the first gap cycle.
    task automatic conv(input logic [DATA_W-1:0] d, input int dly);
        wait_te(1'b1, 200);
        repeat (dly) tick();
        adc_data = d;
        adc_done = 1'b1;
        tick();
        adc_done = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_temp_en"}, int'(temp_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        chk({tag, "_alarm_hi"}, int'(alarm_hi), 0);
        chk({tag, "_alarm_lo"}, int'(alarm_lo), 0);
        chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    initial begin
        int n;
        int last_pub;
        repeat (3) tick();
        RST_sync = 1'b0;
        chk_zero("reset");
        tick();

        enable = 1'b1;
        period = 16'd5;
        tick();
        chk("first_req_immediate", int'(temp_en), 1);
        chk("busy_in_req", int'(busy), 1);

`ifdef TSCHED_AVG_EN
        conv(10'd100, 4);
        chk("avg_none_1", int'(result_valid), 0);
        conv(10'd101, 4);
        chk("avg_none_2", int'(result_valid), 0);
        conv(10'd102, 4);
        chk("avg_none_3", int'(result_valid), 0);
        conv(10'd104, 4);
        chk("avg_valid", int'(result_valid), 1);
        chk("avg_result", int'(result), 101);
        last_pub = 101;
`else
        conv(10'h155, 10);
        chk("first_valid", int'(result_valid), 1);
        chk("first_result", int'(result), 'h155);
        chk("first_te_low", int'(temp_en), 0);
        n = 0;
        while (temp_en == 1'b0 && n < 50) begin
            n++;
            tick();
            if (n == 1) chk("valid_single_cycle", int'(result_valid), 0);
        end
        chk("low_cycles_period5", n, 7);

        // Alarms only follow a new result, not a threshold change.
        thr_hi = 10'h100;
        repeat (2) tick();
        chk("alarm_held", int'(alarm_hi), 0);

        thr_hi = 10'h200;
        thr_lo = 10'h100;
        conv(10'h201, 3);
        chk("alarm_201_hi", int'(alarm_hi), 1);
        chk("alarm_201_lo", int'(alarm_lo), 0);
        conv(10'h0FF, 3);
        chk("alarm_0ff_hi", int'(alarm_hi), 0);
        chk("alarm_0ff_lo", int'(alarm_lo), 1);
        conv(10'h180, 3);
        chk("alarm_180_hi", int'(alarm_hi), 0);
        chk("alarm_180_lo", int'(alarm_lo), 0);
        thr_hi = 10'h010;
        thr_lo = 10'h300;
        conv(10'h050, 3);
        chk("alarm_both_hi", int'(alarm_hi), 1);
        chk("alarm_both_lo", int'(alarm_lo), 1);
        thr_hi = 10'h200;
        thr_lo = 10'h200;
        conv(10'h200, 3);
        chk("alarm_eq_hi", int'(alarm_hi), 0);
        chk("alarm_eq_lo", int'(alarm_lo), 0);
        chk("alarm_eq_result", int'(result), 'h200);
        last_pub = 'h200;
`endif

        // DONE already high on entry is ignored; disable mid-conversion discards the sample.
        adc_done = 1'b1;
        wait_te(1'b1, 200);
        repeat (3) tick();
        chk("done_level_ignored", int'(temp_en), 1);
        enable = 1'b0;
        repeat (4) tick();
        chk("hold_on_abort", int'(temp_en), 1);
        adc_done = 1'b0;
        tick();
        adc_done = 1'b1;
        tick();
        adc_done = 1'b0;
        chk("abort_te_low", int'(temp_en), 0);
        chk("abort_no_valid", int'(result_valid), 0);
        tick();
        chk("abort_gap2_busy", int'(busy), 1);
        tick();
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_te", int'(temp_en), 0);
        chk("abort_result_kept", int'(result), last_pub);

        // Timeout after TO_CYC high cycles, retry with period 0.
        period = 16'd0;
        enable = 1'b1;
        tick();
        n = 0;
        while (temp_en == 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_high_cycles", n, TO_CYC);
        chk("timeout_err_set", int'(timeout_err), 1);
        chk("timeout_no_valid", int'(result_valid), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", int'(timeout_err), 0);
        tick();
        chk("retry_after_gap", int'(temp_en), 1);
        repeat (TO_CYC - 1) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("set_wins_over_clr", int'(timeout_err), 1);
        chk("second_timeout_te", int'(temp_en), 0);

        // Reset in a conversion and in the period wait.
        wait_te(1'b1, 50);
        repeat (2) tick();
        RST_sync = 1'b1;
        tick();
        chk_zero("rst_req");
        RST_sync = 1'b0;
        tick();
        chk("immediate_after_reset", int'(temp_en), 1);
        period = 16'd5;
        conv(10'h123, 2);
        repeat (3) tick();
        chk("in_wait_te", int'(temp_en), 0);
        chk("in_wait_busy", int'(busy), 1);
        RST_sync = 1'b1;
        tick();
        chk_zero("rst_wait");
        RST_sync = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        chk("final_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: got no completion expected completion within 20000 cycles");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tempsense_scheduler.md
# tempsense_scheduler

Periodic sequencer for the on-chip temperature sensor conversion path. It raises the sensor enable once per programmed period and waits for the ADC DONE edge. It captures the conversion word, optionally averages 2^AVG_LOG2 samples, and publishes a result with high/low threshold alarms. It sits in the HF_CLK domain between the register bank and the one-shot temperature conversion controller, whose enable input it drives.

## Interface
- DATA_W, 10, ADC conversion word width
- PERIOD_W, 16, width of conversion period count
- TIMEOUT_CYC, 1024, max HF_CLK cycles in REQ before timeout (≥4)
- AVG_LOG2, 2, log2 of samples averaged per result (only with averaging compiled in)
- HF_CLK  in  1  sole clock; all logic posedge
- RST_sync  in  1  reset, synchronous, active-high
- enable  in  1  scheduler run enable, level
- period  in  PERIOD_W  WAIT-state cycles between conversions; sampled on WAIT entry
- adc_done  in  1  conversion DONE, synchronous to HF_CLK, level
- adc_data  in  DATA_W  conversion word, valid when adc_done is high
- thr_hi, thr_lo  in  DATA_W each  alarm thresholds, unsigned
- err_clr  in  1  single-cycle clear of timeout_err
- temp_en  out  1  enable to conversion controller (arms on its rising edge)
- result  out  DATA_W  latest published temperature word
- result_valid  out  1  one-cycle pulse when result updates
- alarm_hi, alarm_lo  out  1 each  threshold flags, held between results
- timeout_err  out  1  sticky conversion timeout flag
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, REQ, GAP, WAIT. All outputs, counters, accumulator and done_q reset to 0; state resets to IDLE.
- done_q registers adc_done every cycle; a done edge is adc_done & !done_q, counted only in REQ.
- IDLE: temp_en=0. enable=1 → REQ next cycle; the first conversion has no period wait.
- REQ: temp_en=1; the timeout counter increments from 0.
  - On a done edge, capture adc_data and go to GAP.
  - If the counter reaches TIMEOUT_CYC-1 with no edge, set timeout_err, clear the accumulator and sample count, and go to GAP.
- GAP: temp_en=0 for exactly 2 cycles, so the controller sees low and re-arms. Then enable=1 → WAIT, enable=0 → IDLE.
- WAIT: load the counter with period on entry, then decrement each cycle. At 0 → REQ. period=0 → REQ on the cycle after GAP ends. enable=0 → IDLE next cycle.
- enable falls in REQ: hold temp_en until a done edge or timeout (never truncate a conversion). Discard the sample, clear the accumulator, then GAP → IDLE.
- Publishing: result is loaded, result_valid pulses, and the alarms update in the same cycle from the new value.
  - alarm_hi = (result > thr_hi); alarm_lo = (result < thr_lo); both compares unsigned.
  - Both alarms may be set if thr_lo > thr_hi.
- timeout_err is cleared by err_clr. Set wins if a timeout and err_clr occur in the same cycle.
- Reset while in REQ drops temp_en on the next edge. No partial result is published.

## Timing
- Done edge sampled at cycle t → capture at t; result/result_valid/alarms valid at t+1; state = GAP at t+1.
- temp_en low cycles between conversions: 2 + period.
- Conversion interval (done edge → next temp_en rise) = period + 3 cycles.
- Timeout: first temp_en=1 cycle is count 0; timeout_err rises at the edge ending count TIMEOUT_CYC-1.
- result_valid is never high on two consecutive cycles.

## Configuration
- TSCHED_AVG_EN defined: accumulator width is DATA_W+AVG_LOG2, no overflow possible.
  - Each valid sample adds to the accumulator; the sample counter counts to 2^AVG_LOG2.
  - On the final sample, result = (acc + sample) >> AVG_LOG2 (truncating), then the accumulator and counter clear.
  - result_valid pulses once per 2^AVG_LOG2 conversions.
- Not defined: AVG_LOG2 is ignored; every captured sample is published directly, with result_valid at t+1 per conversion.

## Test plan
- Reset, enable=1, period=5, no averaging, adc_data=0x155 with done pulsed 10 cycles after temp_en rises → result=0x155, result_valid one cycle at done+1, temp_en low 7 cycles before next rise.
- TSCHED_AVG_EN, AVG_LOG2=2, samples 100,101,102,104 → one result_valid after the fourth conversion, result=101; none after the first three.
- adc_done never asserted, TIMEOUT_CYC=16 → timeout_err rises after 16 temp_en-high cycles, no result_valid, GAP then retry; err_clr pulse clears it; clear coincident with a second timeout leaves it set.
- thr_hi=0x200, thr_lo=0x100, results 0x201, 0x0FF, 0x180 → alarm_hi/alarm_lo = 1/0, 0/1, 0/0, each changing only on result_valid.
- enable dropped mid-REQ → temp_en stays high until done, no result_valid, 2 low cycles, IDLE, busy=0; adc_done already high on REQ entry is ignored until a fresh rising edge.
- RST_sync asserted in REQ and in WAIT → next cycle temp_en=0, all outputs 0, state IDLE; re-enable starts an immediate conversion.
